// File: rtl/sar_search.sv
// sar_search: successive-approximation search controller.
// Drives probe into a comparator, walks MSB-first, exits early on eq.
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);
  localparam logic [IW-1:0] ONE = IW'(1);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    SEARCH
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] next_probe;
  logic             one_hot;

  // Trial bit under test and the probe for the next lower bit.
  always_comb begin
    one_hot    = $onehot({cmp_gt, cmp_lt, cmp_eq});
    bit_k      = LSB << idx;
    next_probe = (probe & ~bit_k) | (bit_k >> 1);
    if (cmp_gt) next_probe = probe | (bit_k >> 1);
  end

  // Search FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      probe  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      idx    <= TOP;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            probe <= MSB;
            idx   <= TOP;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (!one_hot) begin
            result <= probe;
            err    <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (cmp_eq) begin
            result <= probe;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (idx != '0) begin
            probe <= next_probe;
            idx   <= idx - ONE;
          end else if (cmp_lt) begin
            result <= {probe[WIDTH-1:1], 1'b0};
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            // gt on the last bit cannot come from a sane comparator
            result <= probe;
            err    <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: scoreboard bench for sar_search (WIDTH=4).
// Comparator is modelled in the bench with optional flag forcing.
module tb_sar_search;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cmp_gt;
  logic       cmp_lt;
  logic       cmp_eq;
  logic [3:0] probe;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] result;

  logic [3:0] target;
  logic       frc;
  logic       f_gt;
  logic       f_lt;
  logic       f_eq;

  int tests;
  int fails;

  typedef struct {
    logic [3:0] res;
    logic       err;
  } exp_t;

  logic [3:0] probe_q[$];
  exp_t       exp_q[$];

  sar_search #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .cmp_eq (cmp_eq),
    .probe  (probe),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );

  assign cmp_gt = frc ? f_gt : (target > probe);
  assign cmp_lt = frc ? f_lt : (target < probe);
  assign cmp_eq = frc ? f_eq : (target == probe);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: probes while busy, result/err on done
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        tests++;
        if (probe_q.size() == 0) begin
          fails++;
          $display("FAIL probe_extra: got %0d, none expected", probe);
        end else begin
          logic [3:0] ep;
          ep = probe_q.pop_front();
          if (probe !== ep) begin
            fails++;
            $display("FAIL probe_seq: got %0d, want %0d", probe, ep);
          end
        end
      end
      if (done) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL done_extra: result %0d err %0b", result, err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (result !== e.res || err !== e.err) begin
            fails++;
            $display("FAIL done_result: got %0d/%0b, want %0d/%0b",
                     result, err, e.res, e.err);
          end
        end
      end
    end
  end

  // reference: plain MSB-first binary search over 0..15
  task automatic push_model(input logic [3:0] tgt);
    logic [3:0] acc;
    logic [3:0] p;
    exp_t       e;
    acc = '0;
    for (int k = 3; k >= 0; k--) begin
      p = acc | (4'(1) << k);
      probe_q.push_back(p);
      if (p == tgt) break;
      if (tgt > p) acc = p;
    end
    e.res = tgt;
    e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_exp(input logic [3:0] r, input logic e_err);
    exp_t e;
    e.res = r;
    e.err = e_err;
    exp_q.push_back(e);
  endtask

  // starts at negedge+1 and returns at negedge+1 of the done cycle
  task automatic run(input logic [3:0] tgt, input int force_at,
                     input logic [2:0] fflags, input int kick_at);
    logic [3:0] held;
    bit         seen;
    int         n;
    held   = result;
    target = tgt;
    start  = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    n     = 1;
    seen  = 0;
    while (n <= 8) begin
      if (done) begin
        seen = 1;
        break;
      end
      tests++;
      if (result !== held) begin
        fails++;
        $display("FAIL result_held: got %0d, want %0d", result, held);
      end
      if (n == force_at) begin
        frc = 1'b1;
        {f_gt, f_lt, f_eq} = fflags;
      end
      start = (n == kick_at);
      @(negedge clk); #1;
      n++;
    end
    frc   = 1'b0;
    start = 1'b0;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL done_timeout: target %0d, no done in 8", tgt);
    end
    tests++;
    if (probe_q.size() != 0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_left: probes %0d results %0d, want 0/0",
               probe_q.size(), exp_q.size());
      probe_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    tests++;
    if (probe !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0 || result !== 4'd0) begin
      fails++;
      $display("FAIL reset_vals: p%0d b%0b d%0b e%0b r%0d, want 0",
               probe, busy, done, err, result);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_target11;
    probe_q.push_back(4'd8);
    probe_q.push_back(4'd12);
    probe_q.push_back(4'd10);
    probe_q.push_back(4'd11);
    push_exp(4'd11, 1'b0);
    run(4'd11, 0, 3'b000, 0);
    @(negedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || probe !== 4'd11) begin
      fails++;
      $display("FAIL after_done: d%0b b%0b p%0d, want 0/0/11",
               done, busy, probe);
    end
  endtask

  task automatic test_early_eq;
    probe_q.push_back(4'd8);
    push_exp(4'd8, 1'b0);
    run(4'd8, 0, 3'b000, 0);
    @(negedge clk); #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || probe !== 4'd8) begin
      fails++;
      $display("FAIL early_eq_idle: b%0b d%0b p%0d, want 0/0/8",
               busy, done, probe);
    end
  endtask

  task automatic test_bounds;
    probe_q.push_back(4'd8);
    probe_q.push_back(4'd4);
    probe_q.push_back(4'd2);
    probe_q.push_back(4'd1);
    push_exp(4'd0, 1'b0);
    run(4'd0, 0, 3'b000, 0);
    @(negedge clk); #1;
    probe_q.push_back(4'd8);
    probe_q.push_back(4'd12);
    probe_q.push_back(4'd14);
    probe_q.push_back(4'd15);
    push_exp(4'd15, 1'b0);
    run(4'd15, 0, 3'b000, 0);
    @(negedge clk); #1;
  endtask

  task automatic test_error;
    probe_q.push_back(4'd8);
    probe_q.push_back(4'd12);
    push_exp(4'd12, 1'b1);
    run(4'd11, 2, 3'b110, 0);
    @(negedge clk); #1;
    tests++;
    if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse: e%0b d%0b b%0b, want 0/0/0",
               err, done, busy);
    end
    probe_q.push_back(4'd8);
    probe_q.push_back(4'd4);
    push_exp(4'd4, 1'b1);
    run(4'd2, 2, 3'b000, 0);
    @(negedge clk); #1;
    probe_q.push_back(4'd8);
    probe_q.push_back(4'd12);
    probe_q.push_back(4'd10);
    probe_q.push_back(4'd11);
    push_exp(4'd11, 1'b1);
    run(4'd11, 4, 3'b100, 0);
    @(negedge clk); #1;
  endtask

  task automatic test_start_ignored;
    probe_q.push_back(4'd8);
    probe_q.push_back(4'd4);
    probe_q.push_back(4'd6);
    probe_q.push_back(4'd5);
    push_exp(4'd5, 1'b0);
    run(4'd5, 0, 3'b000, 2);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 16; t++) begin
      push_model(4'(t));
      run(4'(t), 0, 3'b000, 0);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_abort;
    probe_q.push_back(4'd8);
    probe_q.push_back(4'd12);
    target = 4'd11;
    start  = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (probe !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
        result !== 4'd0) begin
      fails++;
      $display("FAIL abort_vals: p%0d b%0b d%0b r%0d, want 0",
               probe, busy, done, result);
    end
    tests++;
    if (probe_q.size() != 0) begin
      fails++;
      $display("FAIL abort_probes: %0d left, want 0", probe_q.size());
      probe_q.delete();
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    probe_q.push_back(4'd8);
    probe_q.push_back(4'd4);
    probe_q.push_back(4'd2);
    probe_q.push_back(4'd3);
    push_exp(4'd3, 1'b0);
    run(4'd3, 0, 3'b000, 0);
    @(negedge clk); #1;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    target = 4'd0;
    frc    = 1'b0;
    f_gt   = 1'b0;
    f_lt   = 1'b0;
    f_eq   = 1'b0;
    #2;
    test_reset();
    test_target11();
    test_early_eq();
    test_bounds();
    test_error();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
